// File: rtl/read_ctl_q.sv
// read_ctl_q: tracks outstanding bus reads and emits one result record per read.
// Read addresses queue up until a slave ack pairs them with data; paired records
// go to a first-word-fall-through result queue with a valid/ready output.
// Optional READ_CTL_Q_TIMEOUT_EN: an outstanding read with no ack for TMO cycles
// is retired as a timeout record {adr, dat=0, tmo=1}.
module read_ctl_q #(
  parameter int AW    = 8,
  parameter int DW    = 8,
  parameter int DEPTH = 4,
  parameter int TMO   = 16
) (
  input  logic                     tb_clk,
  input  logic                     tb_rst,
  input  logic                     stb_i,
  input  logic                     we_i,
  input  logic [AW-1:0]            adr_i,
  input  logic                     ack_i,
  input  logic [DW-1:0]            dat_i,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [AW-1:0]            out_adr,
  output logic [DW-1:0]            out_dat,
  output logic                     out_tmo,
  output logic [$clog2(DEPTH):0]   pend_cnt,
  output logic                     ovf
);
  localparam int PW = $clog2(DEPTH);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  state_t          state_q, state_d;
  logic            in_wait;

  logic [AW-1:0]   pq_mem_q [DEPTH];
  logic [AW-1:0]   pq_mem_d [DEPTH];
  logic [PW:0]     pq_wr_q, pq_wr_d, pq_rd_q, pq_rd_d;
  logic [AW-1:0]   rq_adr_q [DEPTH];
  logic [AW-1:0]   rq_adr_d [DEPTH];
  logic [DW-1:0]   rq_dat_q [DEPTH];
  logic [DW-1:0]   rq_dat_d [DEPTH];
  logic [PW:0]     rq_wr_q, rq_wr_d, rq_rd_q, rq_rd_d;
  logic            ovf_q, ovf_d;

  logic pq_empty, pq_full, rq_empty, rq_full;
  logic pq_push_req, pq_push, pq_pop, pq_drop, ack_pop, tmo_pop;
  logic rq_push, rq_pop, rq_drop;

  // Queue status from the extra-MSB pointer scheme
  always_comb begin
    pq_empty = (pq_wr_q == pq_rd_q);
    pq_full  = (pq_wr_q[PW] != pq_rd_q[PW]) && (pq_wr_q[PW-1:0] == pq_rd_q[PW-1:0]);
    rq_empty = (rq_wr_q == rq_rd_q);
    rq_full  = (rq_wr_q[PW] != rq_rd_q[PW]) && (rq_wr_q[PW-1:0] == rq_rd_q[PW-1:0]);
  end

  // Push/pop decisions; ack only pairs with entries pending before this edge
  always_comb begin
    pq_push_req = stb_i & ~we_i;
    ack_pop     = ack_i & ~pq_empty;
    pq_pop      = ack_pop | tmo_pop;
    pq_push     = pq_push_req & (~pq_full | pq_pop);
    pq_drop     = pq_push_req & pq_full & ~pq_pop;
    rq_pop      = out_valid & out_ready;
    rq_push     = pq_pop & (~rq_full | rq_pop);
    rq_drop     = pq_pop & rq_full & ~rq_pop;
    ovf_d       = ovf_q | pq_drop | rq_drop;
  end

  // Pending queue next state
  always_comb begin
    pq_mem_d = pq_mem_q;
    pq_wr_d  = pq_wr_q;
    pq_rd_d  = pq_rd_q;
    if (pq_push) begin
      pq_mem_d[pq_wr_q[PW-1:0]] = adr_i;
      pq_wr_d = pq_wr_q + 1'b1;
    end
    if (pq_pop) pq_rd_d = pq_rd_q + 1'b1;
  end

  // Result queue next state; timeout records carry zero data
  always_comb begin
    rq_adr_d = rq_adr_q;
    rq_dat_d = rq_dat_q;
    rq_wr_d  = rq_wr_q;
    rq_rd_d  = rq_rd_q;
    if (rq_push) begin
      rq_adr_d[rq_wr_q[PW-1:0]] = pq_mem_q[pq_rd_q[PW-1:0]];
      rq_dat_d[rq_wr_q[PW-1:0]] = ack_pop ? dat_i : '0;
      rq_wr_d = rq_wr_q + 1'b1;
    end
    if (rq_pop) rq_rd_d = rq_rd_q + 1'b1;
  end

  // Queue and flag registers
  always_ff @(posedge tb_clk or posedge tb_rst) begin
    if (tb_rst) begin
      pq_mem_q <= '{default: '0};
      pq_wr_q  <= '0;
      pq_rd_q  <= '0;
      rq_adr_q <= '{default: '0};
      rq_dat_q <= '{default: '0};
      rq_wr_q  <= '0;
      rq_rd_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      pq_mem_q <= pq_mem_d;
      pq_wr_q  <= pq_wr_d;
      pq_rd_q  <= pq_rd_d;
      rq_adr_q <= rq_adr_d;
      rq_dat_q <= rq_dat_d;
      rq_wr_q  <= rq_wr_d;
      rq_rd_q  <= rq_rd_d;
      ovf_q    <= ovf_d;
    end
  end

  // Tracker FSM state register
  always_ff @(posedge tb_clk or posedge tb_rst) begin
    if (tb_rst) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Tracker FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (pq_push) state_d = WAIT;
      WAIT: if (pq_pop && !pq_push && pend_cnt == (PW+1)'(1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Tracker FSM outputs
  always_comb begin
    in_wait = (state_q == WAIT);
  end

`ifdef READ_CTL_Q_TIMEOUT_EN
  localparam int CW = (TMO > 2) ? $clog2(TMO) : 1;
  logic [CW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          rq_tmo_q [DEPTH];
  logic          rq_tmo_d [DEPTH];

  // Expiry yields to a same-cycle ack
  always_comb begin
    tmo_pop = in_wait & ~ack_i & (tmo_cnt_q == CW'(TMO-1));
    if (ack_i || tmo_pop || state_d == IDLE) tmo_cnt_d = '0;
    else if (in_wait)                         tmo_cnt_d = tmo_cnt_q + 1'b1;
    else                                      tmo_cnt_d = tmo_cnt_q;
  end

  // Timeout flag storage alongside each result
  always_comb begin
    rq_tmo_d = rq_tmo_q;
    if (rq_push) rq_tmo_d[rq_wr_q[PW-1:0]] = ~ack_pop;
  end

  // Timeout counter and flag registers
  always_ff @(posedge tb_clk or posedge tb_rst) begin
    if (tb_rst) begin
      tmo_cnt_q <= '0;
      rq_tmo_q  <= '{default: 1'b0};
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      rq_tmo_q  <= rq_tmo_d;
    end
  end

  assign out_tmo = out_valid & rq_tmo_q[rq_rd_q[PW-1:0]];
`else
  assign tmo_pop = 1'b0;
  assign out_tmo = 1'b0;
`endif

  // Head of the result queue falls through; zero when nothing is held
  always_comb begin
    out_valid = ~rq_empty;
    out_adr   = out_valid ? rq_adr_q[rq_rd_q[PW-1:0]] : '0;
    out_dat   = out_valid ? rq_dat_q[rq_rd_q[PW-1:0]] : '0;
    pend_cnt  = pq_wr_q - pq_rd_q;
    ovf       = ovf_q;
  end

endmodule

// File: doc/read_ctl_q.md
READ_CTL_Q -- requirements
Module: read_ctl_q

Interface
REQ-001 Parameter AW, default 8: address width in bits.
REQ-002 Parameter DW, default 8: data width in bits.
REQ-003 Parameter DEPTH, default 4: entries in the pending-address queue and in the result queue; power of 2, >=2.
REQ-004 Parameter TMO, default 16: cycles an outstanding read may wait before timing out; >=2.
REQ-005 The block SHALL be clocked by tb_clk, and reset by tb_rst, which is asynchronous and active-high.
REQ-006 Ports SHALL be:
- tb_clk  in  1  clock.
- tb_rst  in  1  asynchronous active-high reset.
- stb_i  in  1  bus strobe observed.
- we_i  in  1  bus write-enable observed.
- adr_i  in  AW  bus address observed.
- ack_i  in  1  slave acknowledge observed.
- dat_i  in  DW  slave read data observed.
- out_valid  out  1  result record available.
- out_ready  in  1  consumer accepts the record.
- out_adr  out  AW  record address.
- out_dat  out  DW  record data.
- out_tmo  out  1  record is a timeout.
- pend_cnt  out  log2(DEPTH)+1  outstanding reads.
- ovf  out  1  sticky overflow flag.

Function
REQ-007 A read request SHALL be accepted on each tb_clk rising edge with stb_i=1 and we_i=0: adr_i is pushed into the pending queue. Writes (we_i=1) SHALL be ignored.
REQ-008 On an edge with ack_i=1 and the pending queue non-empty, the block SHALL pop the oldest pending address, pair it with dat_i, and push {adr, dat, tmo=0} into the result queue.
REQ-009 An ack_i with the pending queue empty SHALL be ignored, including when a strobe occurs in the same cycle. A same-cycle ack always pairs with an entry pending before that edge.
REQ-010 A simultaneous push and pop of the pending queue SHALL be supported when the queue is full; both succeed.
REQ-011 A request arriving while the pending queue is full, without a same-cycle pop, SHALL be dropped and SHALL set ovf.
REQ-012 A result push while the result queue is full, without a same-cycle out handshake, SHALL drop the record and set ovf; the pending pop still occurs.
REQ-013 The result queue SHALL be first-word-fall-through. A record SHALL appear on out_* one cycle after the pairing edge.
REQ-014 A record SHALL transfer on an edge with out_valid=1 and out_ready=1. out_* SHALL hold stable while out_valid=1 and out_ready=0.
REQ-015 The tracker FSM SHALL have two states:
- IDLE: pending queue empty.
- WAIT: pending queue non-empty.
- IDLE->WAIT on a request push.
- WAIT->IDLE when the last entry pops with no same-cycle push.
REQ-016 pend_cnt SHALL equal the pending occupancy after each edge, in the range 0..DEPTH.
REQ-017 ovf SHALL remain 1 until reset once it is set.
REQ-018 Queue pointers SHALL wrap modulo DEPTH, using an extra MSB to distinguish full from empty.

Reset
REQ-019 While tb_rst=1, the block SHALL force the following, independent of tb_clk:
- out_valid=0, out_adr=0, out_dat=0, out_tmo=0, pend_cnt=0, ovf=0.
- Both queues empty, timeout counter 0, FSM in IDLE.
REQ-020 Reset asserted mid-operation SHALL discard all pending and result entries, and no record SHALL be emitted for them.

Configuration
REQ-021 When macro READ_CTL_Q_TIMEOUT_EN is defined:
- A counter SHALL increment each cycle in WAIT without ack_i.
- The counter SHALL clear on ack_i and on entering IDLE.
- When the counter reaches TMO-1, the oldest pending entry SHALL be popped and {adr, dat=0, tmo=1} pushed to the result queue, and the counter SHALL clear.
- If ack_i coincides with expiry, ack_i SHALL win: a normal record is produced and the counter clears.
REQ-022 When READ_CTL_Q_TIMEOUT_EN is undefined, no counter SHALL exist, out_tmo SHALL be constant 0, and pending entries SHALL wait indefinitely.

Verification
REQ-023 The bench SHALL cover the following scenarios:
- Single read: stb with adr 0x3C, ack with dat 0xA5 next cycle, out_ready=1 -> one record {0x3C, 0xA5, tmo=0}, out_valid for 1 cycle, pend_cnt 0->1->0.
- Pipelined reads: 256 random reads with stb and ack in the same cycle -> each record pairs the previous cycle's address with the current data, in order, ovf=0.
- Pending overflow: DEPTH=4, 5 strobes with no ack -> pend_cnt=4, ovf=1; 4 acks with dat 0x10..0x13 -> records carry the first 4 addresses.
- Backpressure: out_ready=0, 6 completed reads -> 4 records held stable, ovf=1; out_ready=1 -> 4 records drain in order.
- Timeout (macro defined, TMO=16): stb with adr 0x7E, no ack -> record {0x7E, 0x00, tmo=1} 16 cycles later. Ack arriving on the expiry cycle with dat 0x55 -> {0x7E, 0x55, tmo=0}.
- Reset mid-operation: 3 pending and 2 results, assert tb_rst for 1 cycle -> all outputs 0 immediately, no stale records afterwards.
